// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: load/store front end for a word-wide RAM with sub-word read-modify-write
module data_mem_access_unit #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        ram_enable,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rbuf_q;
  logic [1:0]  size_q;
  logic        write_q, signed_q;
  logic        ram_enable_q, ram_rw_q, resp_valid_q, resp_error_q;
  logic [31:0] ram_addr_q, ram_wdata_q, resp_rdata_q;
  logic        idle, wr, sg, err;
  logic [1:0]  sz;
  logic [4:0]  sh, shh;
  logic [31:0] a, wd, src, mask, ins, ld_data, st_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  // In IDLE the live request drives decode so the accepting edge already issues the first RAM cycle
  always_comb begin
    idle    = state_q == IDLE;
    a       = idle ? req_addr : addr_q;
    wd      = idle ? req_wdata : wdata_q;
    sz      = idle ? req_size : size_q;
    wr      = idle ? req_write : write_q;
    sg      = idle ? req_signed : signed_q;
    err     = sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || |a[31:DEPTH_LOG2+2];
    sh      = {a[1:0], 3'b000};
    shh     = {a[1], 4'b0000};
    src     = state_q == READ ? ram_rdata : rbuf_q;
    lane_b  = 8'(src >> sh);
    lane_h  = a[1] ? src[31:16] : src[15:0];
    ld_data = sz == 2'b00 ? {{24{sg & lane_b[7]}}, lane_b} : sz == 2'b01 ? {{16{sg & lane_h[15]}}, lane_h} : src;
    mask    = sz == 2'b00 ? 32'h0000_00ff << sh : 32'h0000_ffff << shh;
    ins     = sz == 2'b00 ? {24'b0, wd[7:0]} << sh : {16'b0, wd[15:0]} << shh;
    st_data = sz == 2'b10 ? wd : (src & ~mask) | ins;
    state_d = idle ? (!req_valid ? IDLE : err ? RESP : (wr && sz == 2'b10) ? WRITE : READ)
            : state_q == READ ? (wr ? WRITE : RESP)
            : state_q == WRITE ? RESP : IDLE;
  end
  // State, latched request, read buffer and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      rbuf_q       <= '0;
      ram_enable_q <= 1'b0;
      ram_rw_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (idle && req_valid) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        write_q  <= req_write;
        signed_q <= req_signed;
      end
      if (state_q == READ) rbuf_q <= ram_rdata;
      ram_enable_q <= state_d == READ || state_d == WRITE;
      ram_rw_q     <= state_d == WRITE;
      ram_addr_q   <= (state_d == READ || state_d == WRITE) ? {2'b00, a[31:2]} : '0;
      ram_wdata_q  <= state_d == WRITE ? st_data : '0;
      resp_valid_q <= state_d == RESP;
      resp_error_q <= idle && state_d == RESP;
      resp_rdata_q <= (state_q == READ && state_d == RESP) ? ld_data : '0;
    end
  end
  assign req_ready  = idle && !reset;
  assign ram_enable = ram_enable_q;
  assign ram_rw     = ram_rw_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
endmodule
